// File: rtl/deser_pkg.sv
// Shared types and width helpers for the parametrised deserializer FIFO.
package deser_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      PUSH    = 2'd1,
      STALL   = 2'd2
   } state_t;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // One extra bit so a completely full queue (len == depth) is representable.
   function automatic int len_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/deser_fifo_param_if.sv
// Serial-in / word-out bus of the deserializer FIFO; master drives the serial
// side and pop requests, slave (the design) returns the queue view.
interface deser_fifo_param_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   logic                                 data_in;
   logic                                 write_in;
   logic                                 deq_in;
   logic [WIDTH-1:0]                     data_out;
   logic [deser_pkg::len_w(DEPTH)-1:0]   len_out;
   logic                                 status_out;
   logic                                 full_out;
   logic                                 empty_out;
   logic                                 overflow_out;

   modport master (
      output data_in, write_in, deq_in,
      input  data_out, len_out, status_out, full_out, empty_out, overflow_out
   );

   modport slave (
      input  data_in, write_in, deq_in,
      output data_out, len_out, status_out, full_out, empty_out, overflow_out
   );
endinterface

// File: rtl/deser_queue.sv
// Circular first-word-fall-through queue; push is accepted when not full or
// when a pop frees the head slot in the same cycle.
module deser_queue
   import deser_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_push,
   input  logic                      i_pop,
   input  logic [WIDTH-1:0]          i_wdata,
   output logic                      o_push_ack,
   output logic [WIDTH-1:0]          o_rdata,
   output logic [len_w(DEPTH)-1:0]   o_len,
   output logic                      o_full,
   output logic                      o_empty
);
   localparam int PTR_W = ptr_w(DEPTH);
   localparam int LEN_W = len_w(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [LEN_W-1:0] r_len;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_full     = (r_len == LEN_W'(DEPTH));
   assign o_empty    = (r_len == '0);
   assign w_do_pop   = i_pop & ~o_empty;
   assign w_do_push  = i_push & (~o_full | w_do_pop);
   assign o_push_ack = w_do_push;
   assign o_len      = r_len;
   assign o_rdata    = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_len    <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_len <= r_len + 1'b1;
            2'b01:   r_len <= r_len - 1'b1;
            default: r_len <= r_len;
         endcase
      end
   end

endmodule

// File: rtl/deser_fifo_param.sv
// Serial-to-parallel deserializer feeding a FWFT queue, with stall and sticky overflow.
// Build option: define DESER_DEQ_EDGE_EN to pop only on the rising edge of deq_in.
//
// state   | meaning
// COLLECT | shifting serial bits in, status_out=1
// PUSH    | one-cycle attempt to write the completed word
// STALL   | queue full, retrying write every cycle, serial bits ignored
module deser_fifo_param
   import deser_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic               clock_1M,
   input  logic               reset,
   deser_fifo_param_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] w_shift_nxt;
   logic             r_overflow;
   logic             w_push;
   logic             w_push_ack;
   logic             w_pop;
   logic             w_status;

   generate
      if (MSB_FIRST) begin : g_msb
         assign w_shift_nxt = {r_shift[WIDTH-2:0], bus.data_in};
      end else begin : g_lsb
         assign w_shift_nxt = {bus.data_in, r_shift[WIDTH-1:1]};
      end
   endgenerate

`ifdef DESER_DEQ_EDGE_EN
   logic r_deq_q;

   always_ff @(posedge clock_1M) begin
      if (reset) r_deq_q <= 1'b0;
      else       r_deq_q <= bus.deq_in;
   end

   assign w_pop = bus.deq_in & ~r_deq_q;
`else
   assign w_pop = bus.deq_in;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_status    = 1'b0;
      unique case (r_state)
         COLLECT: begin
            w_status = 1'b1;
            if (bus.write_in && (r_bit_cnt == LAST_BIT)) w_state_nxt = PUSH;
         end
         PUSH: begin
            w_push      = 1'b1;
            w_state_nxt = w_push_ack ? COLLECT : STALL;
         end
         STALL: begin
            w_push = 1'b1;
            if (w_push_ack) w_state_nxt = COLLECT;
         end
         default: w_state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clock_1M) begin
      if (reset) begin
         r_state    <= COLLECT;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == COLLECT) && bus.write_in) begin
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end else if (w_push && w_push_ack) begin
            r_bit_cnt <= '0;
         end
         if ((r_state == STALL) && bus.write_in) r_overflow <= 1'b1;
      end
   end

   deser_queue #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_queue (
      .i_clk      (clock_1M),
      .i_rst      (reset),
      .i_push     (w_push),
      .i_pop      (w_pop),
      .i_wdata    (r_shift),
      .o_push_ack (w_push_ack),
      .o_rdata    (bus.data_out),
      .o_len      (bus.len_out),
      .o_full     (bus.full_out),
      .o_empty    (bus.empty_out)
   );

   assign bus.status_out   = w_status;
   assign bus.overflow_out = r_overflow;

endmodule

// File: tb/tb_deser_fifo_param.sv
// Directed bench for deser_fifo_param: an MSB-first and an LSB-first instance
// share the same serial stimulus.
module tb_deser_fifo_param;

   logic clock_1M = 1'b0;
   logic reset    = 1'b1;
   logic data_in  = 1'b0;
   logic write_in = 1'b0;
   logic deq_in   = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   deser_fifo_param_if #(.WIDTH(8), .DEPTH(8)) bus_m ();
   deser_fifo_param_if #(.WIDTH(8), .DEPTH(8)) bus_l ();

   assign bus_m.data_in  = data_in;
   assign bus_m.write_in = write_in;
   assign bus_m.deq_in   = deq_in;
   assign bus_l.data_in  = data_in;
   assign bus_l.write_in = write_in;
   assign bus_l.deq_in   = deq_in;

   deser_fifo_param #(.WIDTH(8), .DEPTH(8), .MSB_FIRST(1'b1)) u_dut_m (
      .clock_1M (clock_1M),
      .reset    (reset),
      .bus      (bus_m)
   );

   deser_fifo_param #(.WIDTH(8), .DEPTH(8), .MSB_FIRST(1'b0)) u_dut_l (
      .clock_1M (clock_1M),
      .reset    (reset),
      .bus      (bus_l)
   );

   always #5 clock_1M = ~clock_1M;

   typedef struct {
      logic [7:0] bits;
      logic [7:0] exp_m;
      logic [7:0] exp_l;
   } vec_t;

   vec_t vecs [4];

   task automatic tick();
      @(posedge clock_1M);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // First bit sent is bits[7]; returns just after the edge sampling the last bit.
   task automatic send_bits(input logic [7:0] bits, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         data_in  = bits[i];
         write_in = 1'b1;
         tick();
      end
      write_in = 1'b0;
      data_in  = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] bits);
      send_bits(bits, 8);
      tick();
      tick();
   endtask

   task automatic pop_pulse();
      deq_in = 1'b1;
      tick();
      deq_in = 1'b0;
      tick();
   endtask

   initial begin
      vecs[0] = '{bits: 8'hAA, exp_m: 8'hAA, exp_l: 8'h55};
      vecs[1] = '{bits: 8'h01, exp_m: 8'h01, exp_l: 8'h80};
      vecs[2] = '{bits: 8'hF0, exp_m: 8'hF0, exp_l: 8'h0F};
      vecs[3] = '{bits: 8'h6B, exp_m: 8'h6B, exp_l: 8'hD6};

      tick();
      tick();
      reset = 1'b0;
      check("rst_data",   int'(bus_m.data_out), 0);
      check("rst_len",    int'(bus_m.len_out), 0);
      check("rst_status", int'(bus_m.status_out), 1);
      check("rst_full",   int'(bus_m.full_out), 0);
      check("rst_empty",  int'(bus_m.empty_out), 1);
      check("rst_ovf",    int'(bus_m.overflow_out), 0);

      // Bit order: word visible two edges after its final bit.
      foreach (vecs[k]) begin
         send_word(vecs[k].bits);
         check($sformatf("vec%0d_len", k),   int'(bus_m.len_out), 1);
         check($sformatf("vec%0d_msb", k),   int'(bus_m.data_out), int'(vecs[k].exp_m));
         check($sformatf("vec%0d_lsb", k),   int'(bus_l.data_out), int'(vecs[k].exp_l));
         pop_pulse();
         check($sformatf("vec%0d_empty", k), int'(bus_m.empty_out), 1);
      end

      // FIFO order, then pop on empty.
      send_word(8'hAA);
      send_word(8'h55);
      send_word(8'hCC);
      check("order_len", int'(bus_m.len_out), 3);
      check("order_h0", int'(bus_m.data_out), 'hAA);
      pop_pulse();
      check("order_h1", int'(bus_m.data_out), 'h55);
      pop_pulse();
      check("order_h2", int'(bus_m.data_out), 'hCC);
      pop_pulse();
      pop_pulse();
      check("empty_pop_len",  int'(bus_m.len_out), 0);
      check("empty_pop_data", int'(bus_m.data_out), 0);

      // Fill, stall, overflow, release.
      for (int w = 0; w < 8; w++) send_word(8'(w));
      check("fill_full", int'(bus_m.full_out), 1);
      check("fill_len",  int'(bus_m.len_out), 8);
      check("fill_st",   int'(bus_m.status_out), 1);
      send_word(8'h08);
      check("stall_st",  int'(bus_m.status_out), 0);
      check("stall_ovf0", int'(bus_m.overflow_out), 0);
      data_in  = 1'b1;
      write_in = 1'b1;
      tick();
      write_in = 1'b0;
      tick();
      tick();
      check("ovf_set",    int'(bus_m.overflow_out), 1);
      check("stall_len",  int'(bus_m.len_out), 8);
      deq_in = 1'b1;
      tick();
      deq_in = 1'b0;
      check("rel_st",   int'(bus_m.status_out), 1);
      check("rel_len",  int'(bus_m.len_out), 8);
      check("rel_head", int'(bus_m.data_out), 1);
      check("ovf_sticky", int'(bus_m.overflow_out), 1);
      tick();
      for (int w = 1; w <= 8; w++) begin
         check($sformatf("drain%0d", w), int'(bus_m.data_out), w);
         pop_pulse();
      end
      check("drain_empty", int'(bus_m.empty_out), 1);

      // Held deq_in with 3 words queued.
      send_word(8'h11);
      send_word(8'h22);
      send_word(8'h33);
      deq_in = 1'b1;
      repeat (15) tick();
      deq_in = 1'b0;
      tick();
`ifdef DESER_DEQ_EDGE_EN
      check("hold_len", int'(bus_m.len_out), 2);
`else
      check("hold_len", int'(bus_m.len_out), 0);
`endif
      repeat (4) pop_pulse();

      // Wrap-around: 20 words through an 8-deep queue.
      for (int w = 0; w < 20; w++) begin
         send_word(8'(w * 7 + 3));
         check($sformatf("wrap%0d", w), int'(bus_m.data_out), (w * 7 + 3) & 'hFF);
         pop_pulse();
      end
      check("wrap_len", int'(bus_m.len_out), 0);

      // Reset after 5 of 8 bits drops the partial word and clears overflow.
      send_bits(8'hFF, 5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_len", int'(bus_m.len_out), 0);
      check("mid_rst_ovf", int'(bus_m.overflow_out), 0);
      check("mid_rst_st",  int'(bus_m.status_out), 1);
      send_word(8'h3C);
      check("post_rst_len",  int'(bus_m.len_out), 1);
      check("post_rst_data", int'(bus_m.data_out), 'h3C);
      check("post_rst_lsb",  int'(bus_l.data_out), 'h3C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
